// File: rtl/add4_accumulator.sv
// ============================================================================
// Module      : add4_accumulator
// Description : Sequential front/back end for the add4 ripple adder. Sums
//               N_OPS nibbles per job, tracks a sticky carry-out overflow and
//               returns the result over a valid/ready handshake.
//               Optional macro ADD4_SAT_EN selects saturating accumulation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add4_accumulator #(
  parameter int N_OPS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic [3:0] add_x,
  output logic [3:0] add_y,
  output logic       add_cin,
  input  logic [3:0] add_s,
  input  logic       add_cout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_sum,
  output logic       out_ovf,
  output logic [3:0] out_count,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [3:0] c_N_LAST = 4'(N_OPS);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_acc;
  logic [3:0] w_acc_next;
  logic [3:0] r_count;
  logic [3:0] w_count_next;
  logic       r_ovf;
  logic       w_ovf_next;
  logic [3:0] w_count_inc;

  // The adder sees the live accumulator and the raw nibble; its own carry-in is unused.
  assign add_x     = r_acc;
  assign add_y     = in_data;
  assign add_cin   = 1'b0;

  assign out_sum   = r_acc;
  assign out_ovf   = r_ovf;
  assign out_count = r_count;

  assign w_count_inc = r_count + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_acc   <= 4'd0;
      r_ovf   <= 1'b0;
      r_count <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_ovf   <= w_ovf_next;
      r_count <= w_count_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_ovf_next   = r_ovf;
    w_count_next = r_count;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_acc_next   = 4'd0;
          w_ovf_next   = 1'b0;
          w_count_next = 4'd0;
          w_state_next = S_ACCUM;
        end
      end

      S_ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
`ifdef ADD4_SAT_EN
          // Once pinned at 4'hF every later beat either carries or adds zero, so it stays pinned.
          w_acc_next = add_cout ? 4'hF : add_s;
`else
          w_acc_next = add_s;
`endif
          w_ovf_next   = r_ovf | add_cout;
          w_count_next = w_count_inc;
          if (w_count_inc == c_N_LAST) begin
            w_state_next = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_add4_accumulator.sv
// ============================================================================
// Module      : tb_add4_accumulator
// Description : Scoreboard bench for add4_accumulator with an add4 model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add4_accumulator;

  localparam int N = 4;

  typedef struct {
    logic [3:0] sum;
    logic       ovf;
    logic [3:0] count;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic [3:0] add_x;
  logic [3:0] add_y;
  logic       add_cin;
  logic [3:0] add_s;
  logic       add_cout;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_sum;
  logic       out_ovf;
  logic [3:0] out_count;
  logic       busy;

  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];
  exp_t last_exp;

  always #5 clk = ~clk;

  // Behavioural add4: 4-bit sum with carry-out.
  assign {add_cout, add_s} = 5'(add_x) + 5'(add_y) + 5'(add_cin);

  add4_accumulator #(.N_OPS(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .add_x     (add_x),
    .add_y     (add_y),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_count (out_count),
    .busy      (busy)
  );

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Reference: carries happen exactly when the true total exceeds 15.
  function automatic exp_t model(input int tot);
    exp_t e;
`ifdef ADD4_SAT_EN
    e.sum = (tot >= 16) ? 4'hF : 4'(tot);
`else
    e.sum = 4'(tot % 16);
`endif
    e.ovf   = (tot >= 16);
    e.count = 4'(N);
    return e;
  endfunction

  // Monitor: compares every HOLD cycle, pops on handshake.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got sum %0d with empty scoreboard", out_sum);
      end else begin
        check("out_sum",   int'(out_sum),   int'(sbq[0].sum));
        check("out_ovf",   int'(out_ovf),   int'(sbq[0].ovf));
        check("out_count", int'(out_count), int'(sbq[0].count));
        check("hold_in_ready", int'(in_ready), 0);
        check("hold_busy",     int'(busy),     1);
        if (out_ready) void'(sbq.pop_front());
      end
    end
  end

  task automatic start_job();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_one(input logic [3:0] d, input int gap, input bit poke);
    int w;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = d;
    start    = poke;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    if (!in_ready) check("beat_accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    start    = 1'b0;
    in_data  = 4'($urandom);
  endtask

  task automatic feed(input logic [3:0] v[N], input int maxgap, input bit poke);
    int tot = 0;
    for (int i = 0; i < N; i++) tot += int'(v[i]);
    last_exp = model(tot);
    sbq.push_back(last_exp);
    for (int i = 0; i < N; i++) send_one(v[i], $urandom_range(0, maxgap), poke);
    check("latency_out_valid", int'(out_valid), 1);
  endtask

  task automatic drain(input int dly, input bit with_start);
    int w = 0;
    while (!out_valid && w < 50) begin @(posedge clk); #1; w++; end
    if (!out_valid) check("out_valid_timeout", 0, 1);
    repeat (dly) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    start     = with_start;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] v[N];
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 4'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  int'(in_ready),  0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy",      int'(busy),      0);
    check("rst_sum",       int'(out_sum),   0);
    check("rst_count",     int'(out_count), 0);
    check("rst_ovf",       int'(out_ovf),   0);
    check("rst_add_cin",   int'(add_cin),   0);

    // Directed 1,2,3,4 back-to-back.
    start_job();
    check("accum_busy", int'(busy), 1);
    v = '{4'd1, 4'd2, 4'd3, 4'd4};
    feed(v, 0, 1'b0);
    drain(0, 1'b0);

    // Directed 8,8,1,0 exercises the carry path.
    start_job();
    v = '{4'd8, 4'd8, 4'd1, 4'd0};
    feed(v, 0, 1'b0);
    drain(1, 1'b0);

    // Gapped input and a slow consumer.
    start_job();
    v = '{4'd3, 4'd6, 4'd2, 4'd1};
    for (int i = 0; i < N; i++) begin
      if (i == 0) begin
        last_exp = model(12);
        sbq.push_back(last_exp);
      end
      send_one(v[i], 3, 1'b0);
    end
    drain(5, 1'b0);

    // Reset mid-job discards everything.
    start_job();
    send_one(4'd7, 0, 1'b0);
    send_one(4'd9, 0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_busy",      int'(busy),      0);
    check("midrst_in_ready",  int'(in_ready),  0);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_sum",       int'(out_sum),   0);
    check("midrst_ovf",       int'(out_ovf),   0);
    check("midrst_count",     int'(out_count), 0);
    start_job();
    v = '{4'd5, 4'd5, 4'd5, 4'd5};
    feed(v, 0, 1'b0);
    drain(0, 1'b0);

    // in_valid in IDLE is ignored; start during ACCUM is ignored.
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 4'd6;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("idle_in_ready", int'(in_ready),  0);
    check("idle_count",    int'(out_count), int'(last_exp.count));
    check("idle_sum",      int'(out_sum),   int'(last_exp.sum));
    check("idle_ovf",      int'(out_ovf),   int'(last_exp.ovf));
    @(posedge clk); #1 in_valid = 1'b0;
    start_job();
    v = '{4'd2, 4'd0, 4'd9, 4'd1};
    feed(v, 1, 1'b1);
    drain(0, 1'b0);

    // start coincident with the handshake is ignored.
    start_job();
    v = '{4'd15, 4'd15, 4'd15, 4'd15};
    feed(v, 0, 1'b0);
    drain(2, 1'b1);
    @(negedge clk);
    check("hs_start_busy",      int'(busy),      0);
    check("hs_start_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("hs_start_still_idle", int'(busy), 0);
    start_job();
    check("restart_busy", int'(busy), 1);
    v = '{4'd0, 4'd0, 4'd0, 4'd0};
    feed(v, 0, 1'b0);
    drain(0, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 25; j++) begin
      start_job();
      for (int i = 0; i < N; i++) v[i] = 4'($urandom);
      feed(v, $urandom_range(0, 3), 1'($urandom));
      drain($urandom_range(0, 4), 1'($urandom));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
